// File: rtl/avmm_pio_responder.sv
// Purpose: Avalon-MM PIO responder that drives the LEDs, debounces the mode switches, latches their edges and raises a maskable irq.
// Latency: read data arrives 1 cycle after avs_read. A pin change is accepted into INPUT 2+DEBOUNCE_CYCLES edges after it settles. irq follows one edge later.
// Backpressure: none. There are no wait states, and every read and write is accepted in the cycle it is presented.
//
// Ports:
//   clk, reset          - system clock; synchronous active-high reset
//   avs_address         - word address: 0 INPUT (RO), 1 LED (RW), 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (W1C)
//   avs_read/avs_write  - single-cycle access strobes; avs_writedata carries write data
//   avs_readdata        - read data, qualified by the avs_readdatavalid pulse; holds between reads
//   irq                 - level interrupt, |(EDGE_CAPTURE & IRQ_MASK), registered
//   mode                - asynchronous switch pins
//   q                   - LED drive, taken straight from the LED register
module avmm_pio_responder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LED_WIDTH       = 8,
  parameter int IN_WIDTH        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  output logic                 avs_readdatavalid,
  output logic                 irq,
  input  logic [IN_WIDTH-1:0]  mode,
  output logic [LED_WIDTH-1:0] q
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_INPUT = 2'd0;
  localparam logic [1:0] ADDR_LED   = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  logic [IN_WIDTH-1:0]            sync1;
  logic [IN_WIDTH-1:0]            s;
  logic [IN_WIDTH-1:0]            deb;
  logic [IN_WIDTH-1:0][CNT_W-1:0] cnt;
  logic [IN_WIDTH-1:0]            accept;
  logic [IN_WIDTH-1:0]            edge_cap;
  logic [IN_WIDTH-1:0]            irq_mask;
  logic [IN_WIDTH-1:0]            w1c;
  logic [LED_WIDTH-1:0]           led;
  logic [31:0]                    rd_mux;
  logic                           wr_led;
  logic                           wr_mask;
  logic                           wr_edge;

  // Write-data bits above the register widths are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  assign wr_led  = avs_write && (avs_address == ADDR_LED);
  assign wr_mask = avs_write && (avs_address == ADDR_MASK);
  assign wr_edge = avs_write && (avs_address == ADDR_EDGE);
  assign w1c     = wr_edge ? avs_writedata[IN_WIDTH-1:0] : '0;
  assign q       = led;

  // A bit is accepted on the edge where its counter has already seen DEBOUNCE_CYCLES-1 mismatching cycles and the mismatch is still present.
  always_comb begin
    accept = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      accept[i] = (s[i] != deb[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // The read mux uses the current register contents, so a read paired with a write returns the pre-write value.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_INPUT: rd_mux[IN_WIDTH-1:0]  = deb;
      ADDR_LED:   rd_mux[LED_WIDTH-1:0] = led;
      ADDR_MASK:  rd_mux[IN_WIDTH-1:0]  = irq_mask;
      ADDR_EDGE:  rd_mux[IN_WIDTH-1:0]  = edge_cap;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1             <= '0;
      s                 <= '0;
      deb               <= '0;
      cnt               <= '0;
      edge_cap          <= '0;
      irq_mask          <= '0;
      led               <= '0;
      irq               <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      sync1 <= mode;
      s     <= sync1;

      for (int i = 0; i < IN_WIDTH; i++) begin
        if (s[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          cnt[i] <= '0;
          deb[i] <= s[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end

      // A new edge overrides a simultaneous clear of the same bit.
      edge_cap <= (edge_cap & ~w1c) | accept;

      // irq is built from registered state, so it lags capture or mask changes by one edge.
      irq <= |(edge_cap & irq_mask);

      if (wr_led) begin
        led <= avs_writedata[LED_WIDTH-1:0];
      end
      if (wr_mask) begin
        irq_mask <= avs_writedata[IN_WIDTH-1:0];
      end

      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_avmm_pio_responder.sv
module tb_avmm_pio_responder;

  localparam int DEB = 4;
  localparam int LW  = 8;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    avs_address = '0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid;
  logic          irq;
  logic [IW-1:0] mode = '0;
  logic [LW-1:0] q;

  int n_checks = 0;
  int n_fail   = 0;

  avmm_pio_responder #(
    .DEBOUNCE_CYCLES(DEB),
    .LED_WIDTH(LW),
    .IN_WIDTH(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .irq(irq),
    .mode(mode),
    .q(q)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. An input bit flips once the last DEB synchronised samples all disagree with it.
  logic [IW-1:0] m_deb, m_cap, m_mask, m_pin1, m_pin2;
  logic [LW-1:0] m_led;
  logic          m_irq, m_rdv;
  logic [31:0]   m_rd;
  logic [IW-1:0] m_win[$];

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_deb);
      2'd1:    return 32'(m_led);
      2'd2:    return 32'(m_mask);
      default: return 32'(m_cap);
    endcase
  endfunction

  task automatic model_edge();
    logic [IW-1:0] s_now, acc, w1c;
    bit all_diff;
    if (reset) begin
      m_deb = '0; m_cap = '0; m_mask = '0; m_led = '0;
      m_irq = 1'b0; m_rdv = 1'b0; m_rd = '0;
      m_pin1 = '0; m_pin2 = '0;
      m_win.delete();
      return;
    end
    // A pin value needs two edges to reach the synchronised sample.
    s_now  = m_pin2;
    m_pin2 = m_pin1;
    m_pin1 = mode;
    m_win.push_back(s_now);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    acc = '0;
    if (m_win.size() == DEB) begin
      for (int b = 0; b < IW; b++) begin
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k][b] == m_deb[b]) all_diff = 1'b0;
        acc[b] = all_diff;
      end
    end
    m_rdv = avs_read;
    if (avs_read) m_rd = m_reg(avs_address);
    m_irq = |(m_cap & m_mask);
    w1c   = (avs_write && avs_address == 2'd3) ? avs_writedata[IW-1:0] : '0;
    m_cap = (m_cap & ~w1c) | acc;
    m_deb = m_deb ^ acc;
    if (avs_write && avs_address == 2'd1) m_led  = avs_writedata[LW-1:0];
    if (avs_write && avs_address == 2'd2) m_mask = avs_writedata[IW-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("q", 32'(q), 32'(m_led));
    check_eq("irq", 32'(irq), 32'(m_irq));
    check_eq("rdv", 32'(avs_readdatavalid), 32'(m_rdv));
    check_eq("rdata", avs_readdata, m_rd);
  endtask

  task automatic bus_idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    avs_write = 1'b1; avs_address = a; avs_writedata = d;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    avs_read = 1'b1; avs_address = a;
    tick();
    avs_read = 1'b0;
    d = avs_readdata;
    check_eq("rd_vld", 32'(avs_readdatavalid), 32'd1);
  endtask

  initial begin
    logic [31:0] d;

    // Reset with random bus activity.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      avs_read = 1'($urandom); avs_write = 1'($urandom);
      avs_address = 2'($urandom); avs_writedata = $urandom;
      tick();
    end
    reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    check_eq("rst_q", 32'(q), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_rdv", 32'(avs_readdatavalid), 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus_rd(2'(a), d);
      check_eq("rst_read", d, 32'h0);
    end

    // LED write/readback.
    bus_wr(2'd1, 32'h0000_00A5);
    check_eq("led_q_a5", 32'(q), 32'hA5);
    bus_rd(2'd1, d);
    check_eq("led_rd_a5", d, 32'h0000_00A5);
    bus_wr(2'd1, 32'hFFFF_FF3C);
    check_eq("led_q_3c", 32'(q), 32'h3C);

    // A pulse shorter than DEB is rejected.
    mode[0] = 1'b1;
    bus_idle(3);
    mode[0] = 1'b0;
    bus_idle(8);
    bus_rd(2'd0, d);
    check_eq("short_input", d, 32'h0);
    bus_rd(2'd3, d);
    check_eq("short_edge", d, 32'h0);

    // A stable rise is accepted at edge p+5, so a read at p+5 sees 0 and a read at p+6 sees 1.
    mode[0] = 1'b1;
    bus_idle(5);
    bus_rd(2'd0, d);
    check_eq("acc_before", d, 32'h0);
    bus_rd(2'd0, d);
    check_eq("acc_after", d, 32'h1);
    bus_idle(3);
    bus_rd(2'd3, d);
    check_eq("acc_edge", d, 32'h1);

    // Interrupt flow: mask bit 1, then a rise on mode[1].
    bus_wr(2'd3, 32'h1);
    bus_wr(2'd2, 32'h2);
    mode[1] = 1'b1;
    bus_idle(5);
    bus_rd(2'd3, d);
    check_eq("irq_edge_pre", d, 32'h0);
    check_eq("irq_low_at_cap", 32'(irq), 32'h0);
    bus_rd(2'd3, d);
    check_eq("irq_edge_set", d, 32'h2);
    check_eq("irq_rise", 32'(irq), 32'h1);
    bus_wr(2'd3, 32'h2);
    check_eq("irq_hold_w1c", 32'(irq), 32'h1);
    bus_idle(1);
    check_eq("irq_fall", 32'(irq), 32'h0);
    bus_rd(2'd3, d);
    check_eq("w1c_cleared", d, 32'h0);

    // An unmasked edge captures the bit but leaves irq low.
    mode[0] = 1'b0;
    bus_idle(8);
    bus_rd(2'd3, d);
    check_eq("unmasked_edge", d, 32'h1);
    check_eq("unmasked_irq", 32'(irq), 32'h0);

    // A W1C landing on the acceptance edge loses to the edge.
    bus_wr(2'd2, 32'h3);
    mode[0] = 1'b1;
    bus_idle(5);
    bus_wr(2'd3, 32'h1);
    check_eq("race_irq0", 32'(irq), 32'h1);
    bus_rd(2'd3, d);
    check_eq("race_edge", d, 32'h1);
    check_eq("race_irq1", 32'(irq), 32'h1);

    // Read and write in the same cycle.
    bus_wr(2'd1, 32'h11);
    avs_read = 1'b1; avs_write = 1'b1; avs_address = 2'd1; avs_writedata = 32'h22;
    tick();
    avs_read = 1'b0; avs_write = 1'b0;
    check_eq("rw_rdata", avs_readdata, 32'h11);
    check_eq("rw_q", 32'(q), 32'h22);

    // Reset with the mode[1] fall count at 2; mode[0] stays high through reset.
    mode[1] = 1'b0;
    bus_idle(4);
    check_eq("midcnt_cnt", 32'(dut.cnt[1]), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_deb", 32'(dut.deb), 32'h0);
    check_eq("midrst_cnt", 32'(dut.cnt), 32'h0);
    bus_rd(2'd3, d);
    check_eq("midrst_edge", d, 32'h0);
    bus_idle(5);
    bus_rd(2'd3, d);
    check_eq("held_rise_edge", d, 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 149) == 0);
      avs_read      = 1'($urandom_range(0, 1));
      avs_write     = ($urandom_range(0, 9) < 3);
      avs_address   = 2'($urandom);
      avs_writedata = $urandom;
      for (int b = 0; b < IW; b++) if ($urandom_range(0, 5) == 0) mode[b] = ~mode[b];
      tick();
    end
    reset = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    bus_idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avmm_pio_responder.md
# avmm_pio_responder

Avalon-MM responder that replaces the generic LED/input PIO pair on the board with one register-mapped peripheral answering the Nios II data master. It drives the 8 LEDs, synchronises and debounces the 2 mode switches, records switch edges, and raises a maskable interrupt. It sits inside the FPGA top level between the system interconnect and the board pins.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a switch change is accepted (1 ms at 50 MHz); legal range 2..2^20.
- LED_WIDTH, 8: width of the LED output register.
- IN_WIDTH, 2: number of switch inputs.

- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- avs_address  in  2  word address of the register.
- avs_read  in  1  read strobe, one cycle per access.
- avs_write  in  1  write strobe, one cycle per access.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, qualified by avs_readdatavalid.
- avs_readdatavalid  out  1  one-cycle pulse per accepted read.
- irq  out  1  level interrupt to the CPU.
- mode  in  IN_WIDTH  asynchronous switch pins.
- q  out  LED_WIDTH  LED drive, straight from the LED register.

## Operation
- Register map (unused bits read 0, ignored on write):
  - 0 INPUT (RO): debounced switch state in [IN_WIDTH-1:0]; writes ignored.
  - 1 LED (RW): [LED_WIDTH-1:0] drives q.
  - 2 IRQ_MASK (RW): [IN_WIDTH-1:0], 1 enables that bit's interrupt.
  - 3 EDGE_CAPTURE (R/W1C): bit set on any debounced change (rise or fall) of that input; writing 1 clears, writing 0 leaves unchanged.
- Input path per bit: 2-flop synchroniser → s; debounced bit deb; counter cnt (ceil log2 DEBOUNCE_CYCLES bits).
  - s == deb: cnt <= 0.
  - s != deb and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s, cnt <= 0, capture bit <= 1 on the same edge.
  - Any bounce back to s == deb before acceptance zeroes cnt; a pulse shorter than DEBOUNCE_CYCLES never changes deb.
- irq <= |(EDGE_CAPTURE & IRQ_MASK), registered.
- No wait states: every read and write is accepted in the cycle it is presented.
- Simultaneous events:
  - W1C and a new edge on the same bit in the same cycle: the edge wins and the bit stays 1.
  - avs_read and avs_write in the same cycle: both are performed; the read returns the pre-write value.
  - Write to IRQ_MASK and a capture set in the same cycle: irq uses the new mask in the following cycle.
- Reset values:
  - q, LED, IRQ_MASK, EDGE_CAPTURE, deb, cnt, synchroniser flops: 0.
  - avs_readdata: 0; avs_readdatavalid: 0; irq: 0.
- Reset while a count is in progress abandons it.
- A switch held at 1 through reset is accepted as a normal rise, so EDGE_CAPTURE is set after the normal latency.

## Timing
- Read: avs_read sampled at edge k → avs_readdata valid and avs_readdatavalid high for the cycle after edge k (latency 1). avs_readdata holds its last value when avs_readdatavalid is low.
- Write: register updated at the sampling edge. q shows the new LED value in the following cycle.
- Pin to INPUT/EDGE_CAPTURE: a pin change that is stable before edge p is visible in s after edge p+1 and accepted into deb at edge p+1+DEBOUNCE_CYCLES.
- Pin to irq: irq asserts one edge after the capture bit sets, i.e. p+2+DEBOUNCE_CYCLES when the mask bit is 1.
- W1C to irq deassert: EDGE_CAPTURE clears at the write edge; irq falls one edge later.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset:
  - Stimulus: hold reset 3 cycles with random bus inputs, then release.
  - Required: q=0x00, irq=0, readdatavalid=0; reads of addresses 0-3 all return 0x00000000 with readdatavalid exactly 1 cycle after each read.
- LED write/readback:
  - Stimulus: write 0xA5 to address 1, then read address 1.
  - Required: q=0xA5 the cycle after the write; read returns 0x000000A5.
  - Stimulus: write 0xFFFFFF3C to address 1.
  - Required: q=0x3C.
- Debounce reject/accept:
  - Stimulus: mode[0] high for 3 cycles, then low.
  - Required: INPUT stays 0 and EDGE_CAPTURE stays 0.
  - Stimulus: mode[0] held high for 10 cycles.
  - Required: INPUT=0x1 exactly 2+4 edges after the pin change; EDGE_CAPTURE=0x1.
- Interrupt flow:
  - Stimulus: IRQ_MASK=0x2, then a stable rise on mode[1].
  - Required: irq rises 1 cycle after EDGE_CAPTURE=0x2.
  - Stimulus: write 0x2 to address 3.
  - Required: EDGE_CAPTURE=0 and irq low 1 cycle later.
  - Stimulus: a mode[0] edge while IRQ_MASK=0x2.
  - Required: EDGE_CAPTURE=0x1 and irq stays 0.
- Simultaneous W1C and edge:
  - Stimulus: write 0x1 to address 3 on the exact cycle a new mode[0] edge is accepted.
  - Required: bit 0 stays 1 and irq stays high.
- Read and write in the same cycle:
  - Stimulus: LED=0x11, then assert read and write (0x22) to address 1 in the same cycle.
  - Required: readdata=0x11; q=0x22.
- Reset mid-count:
  - Stimulus: assert reset at cnt=2.
  - Required: deb, cnt and EDGE_CAPTURE return to 0.
